cnn_top: RTL and testbench
==========================

Name: cnn_top

Overview:
- Single-inference 1-D CNN accelerator: a Conv1D layer, then ReLU, then a dense layer, then an argmax classifier.
- Owns four internal BRAMs, all host-loadable through write ports: conv input data, conv kernel, feature map, dense weights.
- On `start`, the block convolves the input, stores features, scores each class, and outputs the winning class index with `done`.

Parameters:
- CONV_DATA_W, 8, signed width of conv input samples and kernel weights
- CONV_ADDR_W, 4, address width of the data and kernel BRAMs (16 entries)
- CONV_ACCUM_W, 24, signed conv accumulator width
- DENSE_DATA_W, 24, feature-map word width (equals CONV_ACCUM_W)
- DENSE_WEIGHT_W, 8, signed dense weight width
- DENSE_ADDR_W, 5, address width of the feature and dense-weight BRAMs (32 entries)
- INPUT_LEN, 8, number of conv input samples
- KERNEL_LEN, 3, number of conv taps
- INPUT_FEATURES, 6, dense inputs (= INPUT_LEN-KERNEL_LEN+1)
- OUTPUT_CLASSES, 3, number of dense outputs

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse that launches an inference
- done  out  1  high when the result is valid
- data_bram_wen  in  1  host write enable, data BRAM
- data_bram_addr  in  CONV_ADDR_W  host write address
- data_bram_din  in  CONV_DATA_W  host write data
- weight_bram_wen / weight_bram_addr / weight_bram_din  in  1/CONV_ADDR_W/CONV_DATA_W  host write port, kernel BRAM
- feature_bram_wen / feature_bram_addr / feature_bram_din  in  1/DENSE_ADDR_W/DENSE_DATA_W  host write port, feature BRAM
- dense_w_bram_wen / dense_w_bram_addr / dense_w_bram_din  in  1/DENSE_ADDR_W/DENSE_WEIGHT_W  host write port, dense-weight BRAM
- final_class_out  out  2  argmax class index

Behaviour:
- Reset: FSM goes to IDLE; done=0; final_class_out=0; accumulators cleared. BRAM contents are not reset.
- BRAMs: single-port, synchronous write, 1-cycle synchronous read.
  - Host writes are accepted only while the FSM is in IDLE or DONE; host writes while busy are ignored.
  - While busy, the FSM owns every BRAM address mux.
- start: accepted in IDLE or DONE. On acceptance, done clears on the next edge. start while busy is ignored.
- Conv stage, for k = 0..INPUT_FEATURES-1:
  - acc = sum over j = 0..KERNEL_LEN-1 of data[k+j]*weight[j].
  - Operands are signed and sign-extended to CONV_ACCUM_W; overflow wraps.
  - ReLU: a negative acc becomes 0.
  - The result is written to feature[k].
- Dense stage, for c = 0..OUTPUT_CLASSES-1:
  - score_c = sum over i of feature[i]*dw[c*INPUT_FEATURES+i].
  - The feature is treated as signed DENSE_DATA_W; the weight is signed.
  - Accumulator is 40 bits signed, no bias.
- Argmax: the strictly-greater comparison keeps the first (lowest) index on ties, so all-equal scores give class 0.
- FSM states and transitions:
  - IDLE -> CONV_RD on start.
  - CONV_RD -> CONV_ACC for each tap (issue address, then accumulate one cycle later).
  - CONV_ACC -> CONV_WR after the last tap; CONV_WR moves to the next k or to DENSE_RD.
  - DENSE_RD and DENSE_ACC loop likewise per feature; DENSE_CMP after each class.
  - DENSE_CMP -> DONE after the last class.
  - DONE -> CONV_RD on start.
- Completion:
  - In DONE, final_class_out is registered and done is held high (level, not a pulse) until the next accepted start or reset.
  - Latency from start to done must be at most 100 cycles.
- Features written by the conv stage overwrite any host-preloaded feature values.
- Reset mid-operation aborts immediately: outputs return to reset values and the FSM returns to IDLE.
- Reruns:
  - Back-to-back runs reuse the BRAM contents.
  - Reloading only the dense weights between runs must change the result accordingly.

Decomposition:
- Package cnn_pkg holds:
  - all width and size constants listed above;
  - the FSM state enum;
  - the dense accumulator width, 40.
- One sub-module, cnn_bram: parameterised single-port synchronous RAM (DATA_W, ADDR_W). It is instantiated four times; the host/FSM port muxing lives in cnn_top.

Test Plan:
- Data [1,0,1,0,1,0,1,0], kernel [1,2,1]; dense weights 5 for class 0 rows and 1 elsewhere (addr = c*6+i) -> features all 2, scores 60/12/12, final_class_out=0, done=1.
- Same BRAMs, reload dense weights with class 1 rows = 5, rerun -> final_class_out=1.
- Reload with class 2 rows = 5, rerun -> final_class_out=2; done deasserts after each start and reasserts within 100 cycles.
- Data all 1, kernel [1,1,1], all dense weights 1 -> equal scores 18 -> final_class_out=0 (tie rule).
- Kernel [-1,-1,-1], data all 1 -> features 0 after ReLU, all scores 0 -> class 0; then assert rst_n low mid-run -> done=0 and final_class_out=0 immediately.
- Host write to dense_w_bram while busy is ignored -> result matches the pre-run weights; start pulsed while busy has no effect.

Source files
------------

// File: rtl/cnn_pkg.sv
// cnn_pkg: shared sizes, widths and FSM states for the 1-D CNN accelerator
package cnn_pkg;
   localparam int CONV_DATA_W    = 8;
   localparam int CONV_ADDR_W    = 4;
   localparam int CONV_ACCUM_W   = 24;
   localparam int DENSE_DATA_W   = 24;
   localparam int DENSE_WEIGHT_W = 8;
   localparam int DENSE_ADDR_W   = 5;
   localparam int INPUT_LEN      = 8;
   localparam int KERNEL_LEN     = 3;
   localparam int INPUT_FEATURES = 6;
   localparam int OUTPUT_CLASSES = 3;
   localparam int DENSE_ACC_W    = 40;
   typedef enum logic [2:0] {
      IDLE, CONV_RD, CONV_ACC, CONV_WR, DENSE_RD, DENSE_ACC, DENSE_CMP, DONE
   } state_t;
endpackage

// File: rtl/cnn_bram.sv
// cnn_bram: single-port RAM with synchronous write and one-cycle registered read
module cnn_bram #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] dout
);
   logic [DATA_W-1:0] mem [2**ADDR_W];
   // write when enabled; read data appears one cycle after the address
   always_ff @(posedge clk) begin
      if (we) mem[addr] <= din;
      dout <= mem[addr];
   end
endmodule

// File: rtl/cnn_top.sv
// cnn_top: Conv1D + ReLU + dense + argmax single-inference accelerator
module cnn_top
   import cnn_pkg::*;
(
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start,
   output logic                      done,
   input  logic                      data_bram_wen,
   input  logic [CONV_ADDR_W-1:0]    data_bram_addr,
   input  logic [CONV_DATA_W-1:0]    data_bram_din,
   input  logic                      weight_bram_wen,
   input  logic [CONV_ADDR_W-1:0]    weight_bram_addr,
   input  logic [CONV_DATA_W-1:0]    weight_bram_din,
   input  logic                      feature_bram_wen,
   input  logic [DENSE_ADDR_W-1:0]   feature_bram_addr,
   input  logic [DENSE_DATA_W-1:0]   feature_bram_din,
   input  logic                      dense_w_bram_wen,
   input  logic [DENSE_ADDR_W-1:0]   dense_w_bram_addr,
   input  logic [DENSE_WEIGHT_W-1:0] dense_w_bram_din,
   output logic [1:0]                final_class_out
);
   localparam logic [2:0] K_LAST = 3'(INPUT_FEATURES - 1);
   localparam logic [1:0] J_LAST = 2'(KERNEL_LEN - 1);
   localparam logic [2:0] I_LAST = 3'(INPUT_FEATURES - 1);
   localparam logic [1:0] C_LAST = 2'(OUTPUT_CLASSES - 1);
   state_t state, state_nx;
   logic [2:0] k, i;
   logic [1:0] j, c, best_idx;
   logic signed [CONV_ACCUM_W-1:0] acc, cprod;
   logic signed [DENSE_ACC_W-1:0] dacc, best, dprod;
   logic [CONV_DATA_W-1:0] data_q, weight_q;
   logic [DENSE_DATA_W-1:0] feat_q, relu;
   logic [DENSE_WEIGHT_W-1:0] dw_q;
   logic [CONV_ADDR_W-1:0] data_addr, weight_addr;
   logic [DENSE_ADDR_W-1:0] feat_addr, dw_addr;
   logic busy, win;
   assign busy = state != IDLE && state != DONE;
   assign done = state == DONE;
   assign cprod = CONV_ACCUM_W'($signed(data_q)) * CONV_ACCUM_W'($signed(weight_q));
   assign dprod = DENSE_ACC_W'($signed(feat_q)) * DENSE_ACC_W'($signed(dw_q));
   assign relu = acc[CONV_ACCUM_W-1] ? '0 : acc;
   assign win = c == 2'd0 || dacc > best;
   assign data_addr = busy ? CONV_ADDR_W'(k) + CONV_ADDR_W'(j) : data_bram_addr;
   assign weight_addr = busy ? CONV_ADDR_W'(j) : weight_bram_addr;
   assign feat_addr = busy ? DENSE_ADDR_W'(state == CONV_WR ? k : i) : feature_bram_addr;
   assign dw_addr = busy ? DENSE_ADDR_W'(c) * DENSE_ADDR_W'(INPUT_FEATURES) + DENSE_ADDR_W'(i)
                         : dense_w_bram_addr;
   cnn_bram #(.DATA_W(CONV_DATA_W), .ADDR_W(CONV_ADDR_W)) u_data (
      .clk(clk), .we(data_bram_wen && !busy), .addr(data_addr), .din(data_bram_din), .dout(data_q));
   cnn_bram #(.DATA_W(CONV_DATA_W), .ADDR_W(CONV_ADDR_W)) u_weight (
      .clk(clk), .we(weight_bram_wen && !busy), .addr(weight_addr), .din(weight_bram_din), .dout(weight_q));
   cnn_bram #(.DATA_W(DENSE_DATA_W), .ADDR_W(DENSE_ADDR_W)) u_feat (
      .clk(clk), .we(busy ? state == CONV_WR : feature_bram_wen), .addr(feat_addr),
      .din(busy ? relu : feature_bram_din), .dout(feat_q));
   cnn_bram #(.DATA_W(DENSE_WEIGHT_W), .ADDR_W(DENSE_ADDR_W)) u_dw (
      .clk(clk), .we(dense_w_bram_wen && !busy), .addr(dw_addr), .din(dense_w_bram_din), .dout(dw_q));
   // state register, aborted to IDLE by reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else state <= state_nx;
   end
   // sequencing: read then accumulate per tap/feature, write or compare at the end of each loop
   always_comb begin
      state_nx = state;
      case (state)
         IDLE, DONE: if (start) state_nx = CONV_RD;
         CONV_RD:    state_nx = CONV_ACC;
         CONV_ACC:   state_nx = j == J_LAST ? CONV_WR : CONV_RD;
         CONV_WR:    state_nx = k == K_LAST ? DENSE_RD : CONV_RD;
         DENSE_RD:   state_nx = DENSE_ACC;
         DENSE_ACC:  state_nx = i == I_LAST ? DENSE_CMP : DENSE_RD;
         DENSE_CMP:  state_nx = c == C_LAST ? DONE : DENSE_RD;
         default:    state_nx = IDLE;
      endcase
   end
   // loop counters, accumulators and running argmax
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         k <= '0;
         j <= '0;
         i <= '0;
         c <= '0;
         acc <= '0;
         dacc <= '0;
         best <= '0;
         best_idx <= '0;
         final_class_out <= '0;
      end else begin
         case (state)
            IDLE, DONE: if (start) begin
               k <= '0;
               j <= '0;
               i <= '0;
               c <= '0;
               acc <= '0;
               dacc <= '0;
            end
            CONV_ACC: begin
               acc <= acc + cprod;
               if (j != J_LAST) j <= j + 2'd1;
            end
            CONV_WR: begin
               acc <= '0;
               j <= '0;
               k <= k + 3'd1;
            end
            DENSE_ACC: begin
               dacc <= dacc + dprod;
               if (i != I_LAST) i <= i + 3'd1;
            end
            DENSE_CMP: begin
               dacc <= '0;
               i <= '0;
               c <= c + 2'd1;
               if (win) begin
                  best <= dacc;
                  best_idx <= c;
               end
               if (c == C_LAST) final_class_out <= win ? c : best_idx;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_cnn_top.sv
// tb_cnn_top: scoreboard bench for cnn_top against a plain-arithmetic CNN model
module tb_cnn_top;
   logic clk = 0, rst_n, start;
   logic done;
   logic data_bram_wen, weight_bram_wen, feature_bram_wen, dense_w_bram_wen;
   logic [3:0] data_bram_addr, weight_bram_addr;
   logic [4:0] feature_bram_addr, dense_w_bram_addr;
   logic [7:0] data_bram_din, weight_bram_din, dense_w_bram_din;
   logic [23:0] feature_bram_din;
   logic [1:0] final_class_out;
   int compared = 0, mismatched = 0;
   int cyc = 0, t0 = 0, ref_lat = 0, lat = 0;
   logic signed [7:0] md[16], mk[16], mdw[32];
   logic [1:0] exp_q[$];
   logic done_q = 0;

   cnn_top dut (
      .clk(clk), .rst_n(rst_n), .start(start), .done(done),
      .data_bram_wen(data_bram_wen), .data_bram_addr(data_bram_addr), .data_bram_din(data_bram_din),
      .weight_bram_wen(weight_bram_wen), .weight_bram_addr(weight_bram_addr), .weight_bram_din(weight_bram_din),
      .feature_bram_wen(feature_bram_wen), .feature_bram_addr(feature_bram_addr), .feature_bram_din(feature_bram_din),
      .dense_w_bram_wen(dense_w_bram_wen), .dense_w_bram_addr(dense_w_bram_addr), .dense_w_bram_din(dense_w_bram_din),
      .final_class_out(final_class_out));

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      compared++;
      if (act !== expv) begin
         mismatched++;
         $display("FAIL %s: got %0d, expected %0d", name, act, expv);
      end
   endtask

   // conv -> relu -> dense -> argmax, straight from the arithmetic definition
   function automatic logic [1:0] model();
      int f[6];
      longint s, best;
      int bi;
      best = 0;
      bi = 0;
      for (int k = 0; k < 6; k++) begin
         int a = 0;
         for (int j = 0; j < 3; j++) a += int'(md[k+j]) * int'(mk[j]);
         f[k] = a < 0 ? 0 : a;
      end
      for (int c = 0; c < 3; c++) begin
         s = 0;
         for (int i = 0; i < 6; i++) s += longint'(f[i]) * longint'(mdw[c*6+i]);
         if (c == 0 || s > best) begin
            best = s;
            bi = c;
         end
      end
      return 2'(bi);
   endfunction

   task automatic wr(input int b, input int a, input int v);
      @(negedge clk);
      data_bram_wen = b == 0;
      weight_bram_wen = b == 1;
      feature_bram_wen = b == 2;
      dense_w_bram_wen = b == 3;
      data_bram_addr = 4'(a);
      weight_bram_addr = 4'(a);
      feature_bram_addr = 5'(a);
      dense_w_bram_addr = 5'(a);
      data_bram_din = 8'(v);
      weight_bram_din = 8'(v);
      feature_bram_din = 24'(v);
      dense_w_bram_din = 8'(v);
      @(negedge clk);
      {data_bram_wen, weight_bram_wen, feature_bram_wen, dense_w_bram_wen} = '0;
   endtask

   task automatic put(input int b, input int a, input int v);
      if (b == 0) md[a] = 8'(v);
      if (b == 1) mk[a] = 8'(v);
      if (b == 3) mdw[a] = 8'(v);
      wr(b, a, v);
   endtask

   task automatic set_dw_rows(input int hot);
      for (int a = 0; a < 18; a++) put(3, a, a / 6 == hot ? 5 : 1);
   endtask

   task automatic set_kernel(input int w0, input int w1, input int w2);
      put(1, 0, w0);
      put(1, 1, w1);
      put(1, 2, w2);
   endtask

   task automatic issue();
      exp_q.push_back(model());
      @(negedge clk);
      start = 1;
      @(negedge clk);
      start = 0;
      t0 = cyc;
      chk("done_clears_after_start", done, 0);
   endtask

   task automatic wait_done(output int l);
      while (!done && cyc - t0 < 110) @(negedge clk);
      l = cyc - t0;
      chk("done_within_100", l <= 100, 1);
   endtask

   task automatic run();
      issue();
      wait_done(lat);
   endtask

   // monitor: each rising done retires the oldest expected class
   always @(negedge clk) begin
      if (done === 1'b1 && done_q !== 1'b1) begin
         if (exp_q.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL unexpected_done: got class %0d, expected no result", final_class_out);
         end else chk("final_class", final_class_out, exp_q.pop_front());
      end
      done_q = done;
   end

   initial begin
      start = 0;
      {data_bram_wen, weight_bram_wen, feature_bram_wen, dense_w_bram_wen} = '0;
      rst_n = 1;
      #2 rst_n = 0;
      repeat (3) @(negedge clk);
      chk("reset_done", done, 0);
      chk("reset_class", final_class_out, 0);
      rst_n = 1;
      @(negedge clk);
      chk("idle_done", done, 0);
      for (int a = 0; a < 8; a++) put(0, a, a % 2 == 0 ? 1 : 0);
      set_kernel(1, 2, 1);
      set_dw_rows(0);
      for (int a = 0; a < 6; a++) wr(2, a, int'($urandom_range(0, 1000)) - 500);
      issue();
      wait_done(ref_lat);
      set_dw_rows(1);
      run();
      for (int a = 0; a < 8; a++) put(0, a, 1);
      set_kernel(1, 1, 1);
      set_dw_rows(-1);
      run();
      set_dw_rows(2);
      run();
      set_kernel(-1, -1, -1);
      issue();
      repeat (20) @(negedge clk);
      rst_n = 0;
      #1;
      chk("abort_done", done, 0);
      chk("abort_class", final_class_out, 0);
      exp_q.delete();
      @(negedge clk);
      rst_n = 1;
      @(negedge clk);
      chk("abort_idle_done", done, 0);
      run();
      for (int a = 0; a < 8; a++) put(0, a, a % 2 == 0 ? 1 : 0);
      set_kernel(1, 2, 1);
      set_dw_rows(0);
      issue();
      for (int a = 0; a < 6; a++) wr(3, a, -128);
      @(negedge clk);
      start = 1;
      @(negedge clk);
      start = 0;
      wait_done(lat);
      chk("busy_start_latency", lat, ref_lat);
      run();
      for (int t = 0; t < 8; t++) begin
         for (int a = 0; a < 8; a++) put(0, a, int'($urandom_range(0, 255)) - 128);
         set_kernel(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
                    int'($urandom_range(0, 255)) - 128);
         for (int a = 0; a < 18; a++) put(3, a, int'($urandom_range(0, 255)) - 128);
         for (int a = 0; a < 6; a++) wr(2, a, int'($urandom_range(0, 1 << 20)));
         run();
      end
      repeat (3) @(negedge clk);
      chk("scoreboard_drained", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
